// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array datapath blocks.
//   DefN / DefAccW : default array dimension and accumulator element width
//   deskew_state_t : output_deskew collection FSM states
//   idx()          : flat element index of (row i, column j) in an n x n matrix
package tpu_pkg;

  localparam int unsigned DefN    = 2;
  localparam int unsigned DefAccW = 16;

  typedef enum logic {COLLECT, FULL} deskew_state_t;

  function automatic int unsigned idx(input int unsigned i, input int unsigned j,
                                      input int unsigned n = DefN);
    return i * n + j;
  endfunction

endpackage

// File: rtl/deskew_col_capture.sv
// Per-column capture bookkeeping for output_deskew.
// Tracks how many rows of one column have been captured into the current matrix.
//   clk, reset  : clock, asynchronous active-low reset
//   beat_valid  : this column presents a result this cycle
//   accept      : the block accepts beats this cycle (top-level in_ready)
//   restart     : handshake cycle, the counter restarts at row 0 for this beat
//   flush       : clear in COLLECT, counter returns to 0 and the beat is discarded
//   wr_en       : write the beat into the matrix at row wr_row
//   wr_row      : row index for the write
//   ovf         : the beat presented this cycle is dropped
//   done_next   : the counter will hold N after this edge
module deskew_col_capture #(
  parameter int unsigned N = 2,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          beat_valid,
  input  logic          accept,
  input  logic          restart,
  input  logic          flush,
  output logic          wr_en,
  output logic [CW-1:0] wr_row,
  output logic          ovf,
  output logic          done_next
);

  localparam logic [CW-1:0] NMax = CW'(N);

  logic [CW-1:0] r_q, r_d, base;
  logic          done;
  logic          at_cap;

  assign done = (r_q == NMax);

  always_comb begin
    // On a handshake the new matrix starts here, so the old count is irrelevant.
    base      = restart ? '0 : r_q;
    at_cap    = done & ~restart;
    wr_en     = beat_valid & accept & ~flush & ~at_cap;
    // Dropped: either stalled, or the column already delivered all N rows.
    ovf       = beat_valid & (~accept | (~flush & at_cap));
    wr_row    = base;
    r_d       = base;
    if (flush) begin
      r_d = '0;
    end else if (wr_en) begin
      r_d = base + CW'(1);
    end
    done_next = (r_d == NMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/output_deskew.sv
// Reassembles the skewed per-column result streams leaving the systolic array into an aligned
// N x N matrix and hands it downstream with a valid/ready handshake.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous flush of a partially collected matrix
//   col_valid  : per-column beat valid; col_data holds column j at [j*ACC_W +: ACC_W]
//   in_ready   : beats are accepted this cycle (array stalls when low)
//   out_valid  : out_matrix holds a complete matrix; out_ready accepts it
//   out_matrix : element (i,j) at [(i*N+j)*ACC_W +: ACC_W]
//   err_ovf    : sticky, a beat was dropped
module output_deskew
  import tpu_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [N-1:0]         col_valid,
  input  logic [N*ACC_W-1:0]   col_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*N*ACC_W-1:0] out_matrix,
  output logic                 err_ovf
);

  localparam int unsigned CW = $clog2(N + 1);

  deskew_state_t state_q, state_d;

  logic [N-1:0]         wr_en;
  logic [N-1:0]         ovf;
  logic [N-1:0]         done_next;
  logic [CW-1:0]        wr_row [N];
  logic                 handshake;
  logic                 flush;
  logic [N*N*ACC_W-1:0] mat_q;
  logic                 err_q;

  assign in_ready   = (state_q == COLLECT) | out_ready;
  assign handshake  = (state_q == FULL) & out_ready;
  // clear only acts while collecting; during the handshake cycle it is ignored.
  assign flush      = (state_q == COLLECT) & clear;
  assign out_valid  = (state_q == FULL);
  assign out_matrix = mat_q;
  assign err_ovf    = err_q;

  for (genvar j = 0; j < N; j++) begin : g_col
    deskew_col_capture #(
      .N (N)
    ) u_col (
      .clk        (clk),
      .reset      (reset),
      .beat_valid (col_valid[j]),
      .accept     (in_ready),
      .restart    (handshake),
      .flush      (flush),
      .wr_en      (wr_en[j]),
      .wr_row     (wr_row[j]),
      .ovf        (ovf[j]),
      .done_next  (done_next[j])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (&done_next) state_d = FULL;
      end
      FULL: begin
        // A handshake beat could in principle complete the next matrix (N == 1).
        if (out_ready) state_d = (&done_next) ? FULL : COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | (|ovf);
    end
  end

  // Writes only happen while in_ready is high, so the matrix is stable throughout FULL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mat_q <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          if (wr_en[j] && (wr_row[j] == CW'(i))) begin
            mat_q[idx(i, j, N)*ACC_W +: ACC_W] <= col_data[j*ACC_W +: ACC_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_output_deskew.sv
module tb_output_deskew;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int MW = N * N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [N-1:0]  col_valid;
  logic [N*W-1:0] col_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_matrix;
  logic          err_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: collected matrix, per-column row counts, full flag, sticky error.
  logic [W-1:0] mmat [N][N];
  int           mcnt [N];
  bit           mfull;
  bit           merr;

  output_deskew #(
    .N     (N),
    .ACC_W (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .col_valid  (col_valid),
    .col_data   (col_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_matrix (out_matrix),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mpack();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*W +: W] = mmat[i][j];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      for (int j = 0; j < N; j++) mmat[i][j] = '0;
    end
    mfull = 0;
    merr  = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic clr,
                       input logic ordy);
    col_valid = v;
    col_data  = d;
    clear     = clr;
    out_ready = ordy;
  endtask

  // Predict the effect of the current inputs, advance one clock, then commit the prediction.
  task automatic step();
    bit           rdy, hs, fl, f, e, all;
    int           c [N];
    logic [W-1:0] m [N][N];
    rdy = !mfull || out_ready;
    hs  = mfull && out_ready;
    fl  = !mfull && clear;
    m   = mmat;
    e   = merr;
    for (int j = 0; j < N; j++) c[j] = hs ? 0 : mcnt[j];
    for (int j = 0; j < N; j++) begin
      if (col_valid[j]) begin
        if (!rdy) e = 1;
        else if (!fl) begin
          if (c[j] == N) e = 1;
          else begin
            m[c[j]][j] = col_data[j*W +: W];
            c[j]++;
          end
        end
      end
    end
    if (fl) for (int j = 0; j < N; j++) c[j] = 0;
    all = 1;
    for (int j = 0; j < N; j++) if (c[j] != N) all = 0;
    f = (mfull && !hs) || all;
    @(posedge clk);
    #1;
    mmat  = m;
    mcnt  = c;
    mfull = f;
    merr  = e;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  // Standard skewed 2x2 fill: (0,0)=a (1,0)=b (0,1)=c (1,1)=d, ends in FULL.
  task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] d);
    drive(2'b01, {16'd0, a}, 1'b0, 1'b0); step();
    drive(2'b11, {c, b},     1'b0, 1'b0); step();
    drive(2'b10, {d, 16'd0}, 1'b0, 1'b0); step();
    drive(2'b00, '0,         1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    model_reset();
    #12;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++;
    if (out_matrix !== '0) begin n_bad++; $display("FAIL reset_matrix got %h want 0", out_matrix); end
    n_cmp++;
    if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_ovf); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_skewed();
    drive(2'b01, {16'd0, 16'd11}, 1'b0, 1'b0); step();
    drive(2'b11, {16'd12, 16'd21}, 1'b0, 1'b0); step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL skew_early_valid got %b want 0", out_valid); end
    drive(2'b10, {16'd22, 16'd0}, 1'b0, 1'b0); step();
    drive('0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL skew_valid got %b want 1", out_valid); end
    n_cmp++;
    if (out_matrix !== 64'h0016_0015_000C_000B) begin
      n_bad++; $display("FAIL skew_matrix got %h want 0016_0015_000c_000b", out_matrix);
    end
    n_cmp++;
    if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL skew_err got %b want 0", err_ovf); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      drive('0, '0, 1'b0, 1'b0); step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_matrix !== 64'h0016_0015_000C_000B) begin
        n_bad++; $display("FAIL bp_hold got v=%b m=%h want v=1 m=0016_0015_000c_000b", out_valid,
                          out_matrix);
      end
    end
    drive('0, '0, 1'b0, 1'b1);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready got %b want 1", in_ready); end
    step();
    drive('0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    fill(16'd1, 16'd2, 16'd3, 16'd4);
    drive(2'b01, {16'd0, 16'd5}, 1'b1, 1'b1); step();   // handshake; clear ignored
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got %b want 0", out_valid); end
    drive(2'b11, {16'd7, 16'd6}, 1'b0, 1'b0); step();
    drive(2'b10, {16'd8, 16'd0}, 1'b0, 1'b0); step();
    drive('0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_matrix !== 64'h0008_0006_0007_0005) begin
      n_bad++; $display("FAIL b2b_matrix got v=%b m=%h want v=1 m=0008_0006_0007_0005", out_valid,
                        out_matrix);
    end
    n_cmp++;
    if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_err got %b want 0", err_ovf); end
    drive('0, '0, 1'b0, 1'b1); step();
    drive('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    drive(2'b01, {16'd0, 16'd90}, 1'b0, 1'b0); step();
    drive(2'b10, {16'd91, 16'd0}, 1'b0, 1'b0); step();
    drive(2'b11, {16'd92, 16'd93}, 1'b1, 1'b0); step();  // discarded by clear
    drive(2'b01, {16'd0, 16'd31}, 1'b0, 1'b0); step();
    drive(2'b11, {16'd32, 16'd41}, 1'b0, 1'b0); step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_novalid got %b want 0", out_valid); end
    drive(2'b10, {16'd42, 16'd0}, 1'b0, 1'b0); step();
    drive('0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_matrix !== 64'h002A_0029_0020_001F) begin
      n_bad++; $display("FAIL clear_matrix got v=%b m=%h want v=1 m=002a_0029_0020_001f", out_valid,
                        out_matrix);
    end
    n_cmp++;
    if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL clear_err got %b want 0", err_ovf); end
    drive('0, '0, 1'b0, 1'b1); step();
    drive('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    fill(16'd51, 16'd52, 16'd53, 16'd54);
    drive(2'b11, {16'hEEEE, 16'hDDDD}, 1'b0, 1'b0); step();
    drive('0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_full_err got %b want 1", err_ovf); end
    n_cmp++;
    if (out_valid !== 1'b1 || out_matrix !== 64'h0036_0034_0035_0033) begin
      n_bad++; $display("FAIL ovf_full_matrix got v=%b m=%h want v=1 m=0036_0034_0035_0033",
                        out_valid, out_matrix);
    end
    apply_reset();
    drive(2'b01, {16'd0, 16'd61}, 1'b0, 1'b0); step();
    drive(2'b01, {16'd0, 16'd62}, 1'b0, 1'b0); step();
    n_cmp++;
    if (err_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_pre_err got %b want 0", err_ovf); end
    drive(2'b11, {16'd63, 16'd99}, 1'b0, 1'b0); step();  // col0 extra dropped, col1 kept
    n_cmp++;
    if (err_ovf !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_extra got e=%b v=%b want e=1 v=0", err_ovf, out_valid);
    end
    drive(2'b10, {16'd64, 16'd0}, 1'b0, 1'b0); step();
    drive('0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_matrix !== 64'h0040_003E_003F_003D) begin
      n_bad++; $display("FAIL ovf_collect_matrix got v=%b m=%h want v=1 m=0040_003e_003f_003d",
                        out_valid, out_matrix);
    end
    drive('0, '0, 1'b0, 1'b1); step();
    drive('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midop();
    drive(2'b01, {16'd0, 16'd71}, 1'b0, 1'b0); step();
    drive(2'b11, {16'd72, 16'd73}, 1'b0, 1'b0); step();
    drive('0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_matrix !== '0 || err_ovf !== 1'b0) begin
      n_bad++; $display("FAIL midop_reset got v=%b m=%h e=%b want all 0", out_valid, out_matrix,
                        err_ovf);
    end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    fill(16'd81, 16'd82, 16'd83, 16'd84);
    n_cmp++;
    if (out_valid !== 1'b1 || out_matrix !== 64'h0054_0052_0053_0051 || err_ovf !== 1'b0) begin
      n_bad++; $display("FAIL midop_fresh got v=%b m=%h e=%b want v=1 m=0054_0052_0053_0051 e=0",
                        out_valid, out_matrix, err_ovf);
    end
    drive('0, '0, 1'b0, 1'b1); step();
    drive('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    for (int k = 0; k < 400; k++) begin
      for (int j = 0; j < N; j++) v[j] = ($urandom_range(9, 0) < 6);
      d = {$urandom, $urandom};
      drive(v, d, ($urandom_range(19, 0) == 0), $urandom_range(1, 0) == 1);
      #1;
      n_cmp++;
      if (in_ready !== (!mfull || out_ready)) begin
        n_bad++; $display("FAIL rnd_ready cyc %0d got %b want %b", k, in_ready, !mfull || out_ready);
      end
      step();
      n_cmp++;
      if (out_valid !== mfull || err_ovf !== merr) begin
        n_bad++; $display("FAIL rnd_status cyc %0d got v=%b e=%b want v=%b e=%b", k, out_valid,
                          err_ovf, mfull, merr);
      end
      if (mfull) begin
        n_cmp++;
        if (out_matrix !== mpack()) begin
          n_bad++; $display("FAIL rnd_matrix cyc %0d got %h want %h", k, out_matrix, mpack());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    model_reset();
    test_skewed();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_overflow();
    test_reset_midop();
    apply_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
